// File: rtl/weight_stream_mem.sv
// Weight store: fills from a valid/ready word stream, then bursts LANES words per beat to the MAC lanes.
// Read latency 1 cycle from start; output register holds while rd_valid & !rd_ready; load runs at 1 word/cycle.
module weight_stream_mem #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 1024,
  parameter  int LANES = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [DW-1:0]       ld_data,
  output logic                ld_ready,
  output logic                ld_done,
  input  logic                rd_start,
  input  logic [AW-1:0]       rd_base,
  input  logic [AW:0]         rd_beats,
  output logic                rd_valid,
  output logic [LANES*DW-1:0] rd_data,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic                rd_done,
  output logic                busy
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   NBEATS    = (AW+1)'(DEPTH / LANES);
  localparam logic [AW:0]   LANES_W   = (AW+1)'(LANES);
  localparam logic [AW:0]   ONE_W     = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_A     = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [AW:0]         rem_q, rem_d;
  logic                rd_valid_q, rd_valid_d;
  logic [LANES*DW-1:0] rd_data_q, rd_data_d;
  logic                rd_last_q, rd_last_d;
  logic                ld_done_q, ld_done_d;
  logic                rd_done_q, rd_done_d;

  logic [DW-1:0]       mem [DEPTH];
  logic                mem_we;
  logic [AW-1:0]       src_addr;
  logic [AW-1:0]       next_ptr;
  logic [AW:0]         beats_sat;
  logic [LANES*DW-1:0] beat_dat;

  // rptr and rd_base are always < DEPTH and offsets are <= LANES <= DEPTH, so one subtract wraps.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW:0] off);
    logic [AW:0] sum;
    sum = {1'b0, a} + off;
    if (sum >= DEPTH_W) sum = sum - DEPTH_W;
    return sum[AW-1:0];
  endfunction

  assign src_addr  = (state_q == S_IDLE) ? rd_base : rptr_q;
  assign next_ptr  = wrap_add(src_addr, LANES_W);
  assign beats_sat = (rd_beats > NBEATS) ? NBEATS : rd_beats;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [AW-1:0] lane_addr;
    assign lane_addr               = wrap_add(src_addr, (AW+1)'(j));
    assign beat_dat[j*DW +: DW]    = mem[lane_addr];
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rem_d      = rem_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    ld_done_d  = 1'b0;
    rd_done_d  = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d = S_LOAD;
          wptr_d  = '0;
        end else if (rd_start) begin
          if (beats_sat == '0) begin
            rd_done_d = 1'b1;
          end else begin
            // First beat is fetched straight from rd_base so it is visible one cycle after start.
            state_d    = S_STREAM;
            rd_valid_d = 1'b1;
            rd_data_d  = beat_dat;
            rd_last_d  = (beats_sat == ONE_W);
            rem_d      = beats_sat - ONE_W;
            rptr_d     = next_ptr;
          end
        end
      end

      S_LOAD: begin
        if (ld_valid) begin
          mem_we = 1'b1;
          if (wptr_q == LAST_ADDR) begin
            wptr_d    = '0;
            ld_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            wptr_d = wptr_q + ONE_A;
          end
        end
      end

      S_STREAM: begin
        if (!rd_valid_q || rd_ready) begin
          if (rd_last_q) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            rd_done_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = beat_dat;
            rd_last_d  = (rem_q == ONE_W);
            rem_d      = rem_q - ONE_W;
            rptr_d     = next_ptr;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      ld_done_q  <= ld_done_d;
      rd_done_q  <= rd_done_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= ld_data;
  end

  assign ld_ready = (state_q == S_LOAD);
  assign ld_done  = ld_done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign rd_done  = rd_done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_weight_stream_mem.sv
// Directed bench for weight_stream_mem: load, aligned/wrapped/stalled/zero/saturated bursts, reset mid-stream.
module tb_weight_stream_mem;

  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int LANES = 4;
  localparam int AW    = 10;
  localparam int BW    = DW * LANES;

  logic          clk;
  logic          reset;
  logic          ld_start, ld_valid, ld_ready, ld_done;
  logic [DW-1:0] ld_data;
  logic          rd_start, rd_valid, rd_ready, rd_last, rd_done, busy;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_beats;
  logic [BW-1:0] rd_data;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            hs_cnt   = 0;
  int            hs_before;
  int            bad;
  logic [DW-1:0] exp_mem [DEPTH];

  weight_stream_mem #(.DW(DW), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_beats (rd_beats),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .rd_done  (rd_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_valid === 1'b1 && rd_ready === 1'b1) hs_cnt <= hs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_beat(input int base);
    logic [BW-1:0] v;
    for (int j = 0; j < LANES; j++) v[j*DW +: DW] = exp_mem[(base + j) % DEPTH];
    return v;
  endfunction

  task automatic check_beat(input string tag, input int base, input logic last);
    check({tag, "_vld"},  64'(rd_valid), 64'd1);
    check({tag, "_dat"},  64'(rd_data),  64'(exp_beat(base)));
    check({tag, "_last"}, 64'(rd_last),  64'(last));
  endtask

  task automatic start_read(input int base, input int beats);
    rd_base  = AW'(base);
    rd_beats = (AW+1)'(beats);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_start = 0; ld_valid = 0; ld_data = '0;
    rd_start = 0; rd_base = '0; rd_beats = '0; rd_ready = 1'b1;
    tick(); tick();
    check("rst_ld_ready", 64'(ld_ready), 0);
    check("rst_rd_valid", 64'(rd_valid), 0);
    check("rst_rd_data",  64'(rd_data),  0);
    check("rst_busy",     64'(busy),     0);
    check("rst_dones",    64'({ld_done, rd_done, rd_last}), 0);
    reset = 1'b0;
    tick();

    // Load mem[i] = i with a gap before every word.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b0;
      tick();
      if (ld_ready !== 1'b1 || ld_done !== 1'b0) bad++;
      ld_valid = 1'b1;
      ld_data  = DW'(i);
      exp_mem[i] = DW'(i);
      if (ld_ready !== 1'b1 || ld_done !== 1'b0) bad++;
      tick();
    end
    ld_valid = 1'b0;
    check("load_ready_throughout", 64'(bad), 0);
    check("load_done_pulse", 64'(ld_done), 1);
    check("load_busy_low",   64'(busy),    0);
    tick();
    check("load_done_single", 64'(ld_done), 0);

    // Aligned 4-beat burst at full throughput.
    start_read(0, 4);
    check_beat("b0_beat0", 0, 1'b0);
    tick(); check_beat("b0_beat1", 4, 1'b0);
    tick(); check_beat("b0_beat2", 8, 1'b0);
    tick(); check_beat("b0_beat3", 12, 1'b1);
    tick();
    check("b0_vld_after", 64'(rd_valid), 0);
    check("b0_last_after", 64'(rd_last), 0);
    check("b0_done", 64'(rd_done), 1);
    check("b0_busy", 64'(busy), 0);
    check("b0_data_hold", 64'(rd_data), 64'(exp_beat(12)));
    tick();
    check("b0_done_single", 64'(rd_done), 0);

    // Single beat wrapping past the top of the array.
    start_read(1022, 1);
    check_beat("wrap_beat", 1022, 1'b1);
    tick();
    check("wrap_done", 64'(rd_done), 1);
    tick();

    // Stall beat 1 for three cycles; a load start during the stall must be ignored.
    hs_before = hs_cnt;
    start_read(8, 3);
    check_beat("stall_beat0", 8, 1'b0);
    tick();
    check_beat("stall_beat1", 12, 1'b0);
    rd_ready = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check_beat("stall_hold1", 12, 1'b0);
    check("stall_ld_ignored", 64'(ld_ready), 0);
    tick(); check_beat("stall_hold2", 12, 1'b0);
    tick(); check_beat("stall_hold3", 12, 1'b0);
    rd_ready = 1'b1;
    tick(); check_beat("stall_beat2", 16, 1'b1);
    tick();
    check("stall_done", 64'(rd_done), 1);
    check("stall_handshakes", 64'(hs_cnt - hs_before), 3);
    tick();

    // Zero-length burst.
    start_read(40, 0);
    check("zero_vld", 64'(rd_valid), 0);
    check("zero_done", 64'(rd_done), 1);
    check("zero_busy", 64'(busy), 0);
    tick();
    check("zero_done_single", 64'(rd_done | rd_valid), 0);

    // Both starts together: load wins, then reload with a new pattern.
    ld_start = 1'b1;
    rd_start = 1'b1;
    rd_base  = '0;
    rd_beats = 11'd4;
    tick();
    ld_start = 1'b0;
    rd_start = 1'b0;
    check("both_ld_ready", 64'(ld_ready), 1);
    check("both_no_read", 64'(rd_valid), 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(16'hFFFF ^ (i * 37));
      exp_mem[i] = ld_data;
      if (rd_valid !== 1'b0) bad++;
      tick();
    end
    ld_valid = 1'b0;
    check("both_read_ignored", 64'(bad), 0);
    check("reload_done", 64'(ld_done), 1);
    tick();

    // Oversized burst saturates to DEPTH/LANES beats and wraps once.
    start_read(4, 300);
    bad = 0;
    for (int k = 0; k < DEPTH / LANES; k++) begin
      if (rd_valid !== 1'b1 || rd_data !== exp_beat(4 + k * LANES) ||
          rd_last !== (k == DEPTH / LANES - 1)) bad++;
      tick();
    end
    check("sat_beats", 64'(bad), 0);
    check("sat_done", 64'(rd_done), 1);
    tick();

    // Reset after beat 1 of a stream.
    start_read(0, 4);
    check_beat("rst_beat0", 0, 1'b0);
    tick();
    check_beat("rst_beat1", 4, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_vld",  64'(rd_valid), 0);
    check("midrst_data", 64'(rd_data),  0);
    check("midrst_last", 64'(rd_last),  0);
    check("midrst_busy", 64'(busy),     0);
    #3 reset = 1'b0;
    tick();
    check("midrst_no_done", 64'(rd_done | rd_valid | busy), 0);
    start_read(0, 2);
    check_beat("retain_beat0", 0, 1'b0);
    tick();
    check_beat("retain_beat1", 4, 1'b1);
    tick();
    check("retain_done", 64'(rd_done), 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
